phys_free_list: RTL
===================

Name: phys_free_list

Overview:
- Circular FIFO of free physical register indices for the rename stage.
- Sits between decode/dispatch rename (consumer: allocates a destination preg) and ROB commit (producer: returns the stale preg of each retiring instruction).
- Keeps a speculative head and a committed head. On a branch mispredict flush, every speculatively allocated preg returns to the list in one cycle.

Parameters:
- DEPTH, FL_DEPTH (32): number of entries.
- PWIDTH, PHYS_WIDTH (6): width of a physical register index.
- BASE, ARCH_REGS (32): first preg loaded at reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_req  in  1  rename consumes the head preg this cycle
- alloc_valid  out  1  list non-empty; head preg is valid
- alloc_preg  out  PWIDTH  preg at speculative head
- free_req  in  1  commit returns a preg
- free_preg  in  PWIDTH  preg being returned
- commit_alloc  in  1  retiring instruction had allocated a preg; advances committed head
- flush  in  1  mispredict recovery
- count  out  $clog2(DEPTH)+1  free entries visible to rename
- fl_err  out  1  sticky error flag (FREELIST_CHECK_EN only; 0 otherwise)

Behaviour:
- Storage: DEPTH x PWIDTH register array.
- Pointers are ADDR+1 bits wide (wrap bit on top):
  - wr_ptr: tail
  - rd_ptr: speculative head
  - crd_ptr: committed head
- count = wr_ptr - rd_ptr (modulo arithmetic).
- Reset (rst high at posedge):
  - entry i = BASE+i
  - rd_ptr = crd_ptr = 0
  - wr_ptr = DEPTH (wrap bit set, full)
  - count = DEPTH, alloc_valid = 1, alloc_preg = BASE, fl_err = 0
  - rst overrides every other input on that edge.
- alloc_valid = (count != 0).
- alloc_preg = mem[rd_ptr], combinational from registered state, zero-latency read.
- Alloc: on alloc_req && alloc_valid, rd_ptr increments at the edge. alloc_req while empty is ignored; no state change.
- Free: on free_req, mem[wr_ptr] = free_preg and wr_ptr increments. The new entry is visible to alloc_preg the next cycle; there is no same-cycle bypass into an empty list.
  - free_req when wr_ptr - crd_ptr == DEPTH is illegal and dropped (flagged by the check feature).
- Commit: on commit_alloc, crd_ptr increments.
  - crd_ptr never passes rd_ptr; commit_alloc when crd_ptr == rd_ptr is dropped.
- Simultaneous alloc and free: both take effect; count unchanged.
- Flush: rd_ptr <= crd_ptr_next, where crd_ptr_next includes a same-cycle commit_alloc.
  - Any alloc_req in the flush cycle is ignored.
  - A same-cycle free_req still enqueues, because commit is older than the flush.
  - Resulting count = wr_ptr_next - crd_ptr_next.
- Wrap-around: pointers wrap modulo 2*DEPTH. full = (MSB differ, low bits equal); empty = (pointers equal).
- Invariant: crd_ptr <= rd_ptr <= wr_ptr in circular order; count <= DEPTH.

Optional Feature:
- Macro: FREELIST_CHECK_EN.
- Enabled:
  - Maintain a 2^PWIDTH-bit bitmap in_list, set at reset for BASE..BASE+DEPTH-1.
  - Set fl_err (sticky until rst) on any of:
    - free of a preg already in_list
    - free of preg 0
    - free when full
    - alloc_req while empty
    - commit_alloc with crd_ptr == rd_ptr
  - The offending free is dropped.
- Disabled: no bitmap; fl_err tied to 0; illegal operations behave as listed in Behaviour.

Decomposition:
- Add fl_ptr_t (FL_ADDR_WIDTH+1 bits) to rv32i_types beside FL_DEPTH, FL_ADDR_WIDTH, PHYS_WIDTH, ARCH_REGS; reuse those constants.
- No sub-module needed: pointer logic is flat.

Test Plan:
- Reset, then 32 consecutive alloc_req -> alloc_preg 32,33,...,63; alloc_valid drops after the 32nd; count=0.
- From empty, free_req preg 7 -> next cycle alloc_valid=1, alloc_preg=7, count=1; same-cycle alloc while empty is ignored.
- Alloc 3 (32,33,34), commit_alloc 1, flush -> rd_ptr = crd_ptr; next alloc_preg=33; count=31.
- Flush in the same cycle as commit_alloc and free_req preg 40 -> committed head advances first; preg 40 enqueued at tail; count reflects both.
- 100 cycles of random alloc/free/commit with pointers wrapping more than twice -> returned order matches a FIFO scoreboard; count never exceeds 32.
- With FREELIST_CHECK_EN: free preg 45 while still in list -> fl_err=1 next cycle, stays high, count unchanged; without the macro fl_err stays 0.

Source files
------------

// File: rtl/phys_free_list_pkg.sv
// Shared rename-stage types: free-list geometry and pointer type.
package rv32i_types;

   localparam int FL_DEPTH      = 32;
   localparam int FL_ADDR_WIDTH = $clog2(FL_DEPTH);
   localparam int PHYS_WIDTH    = 6;
   localparam int ARCH_REGS     = 32;

   // Free-list pointer: FL_ADDR_WIDTH index bits plus one wrap bit on top.
   typedef logic [FL_ADDR_WIDTH:0] fl_ptr_t;

endpackage

// File: rtl/phys_free_list.sv
// Circular free list of physical register indices with speculative and committed heads.
// Optional FREELIST_CHECK_EN adds an in-list bitmap and a sticky fl_err flag.
import rv32i_types::*;

module phys_free_list #(
   parameter int DEPTH  = FL_DEPTH,
   parameter int PWIDTH = PHYS_WIDTH,
   parameter int BASE   = ARCH_REGS,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_req,
   output logic              alloc_valid,
   output logic [PWIDTH-1:0] alloc_preg,
   input  logic              free_req,
   input  logic [PWIDTH-1:0] free_preg,
   input  logic              commit_alloc,
   input  logic              flush,
   output logic [AW:0]       count,
   output logic              fl_err
);

   logic [AW:0]       wr_q, wr_d, rd_q, rd_d, crd_q, crd_d;
   logic [PWIDTH-1:0] mem_q [DEPTH];
   logic [PWIDTH-1:0] mem_d [DEPTH];
   logic              list_full, do_alloc, do_commit, do_free, free_legal;

   assign count       = wr_q - rd_q;
   assign alloc_valid = (count != '0);
   assign alloc_preg  = mem_q[rd_q[AW-1:0]];

   // Fullness is judged against the committed head: speculatively allocated
   // pregs still occupy their slots until commit or flush.
   assign list_full = ((wr_q - crd_q) == (AW+1)'(DEPTH));
   assign do_alloc  = alloc_req && alloc_valid && !flush;
   assign do_commit = commit_alloc && (crd_q != rd_q);
   assign do_free   = free_req && free_legal;

   always_comb begin
      mem_d = mem_q;
      if (do_free) mem_d[wr_q[AW-1:0]] = free_preg;
      wr_d  = wr_q + (AW+1)'(do_free);
      crd_d = crd_q + (AW+1)'(do_commit);
      rd_d  = flush ? crd_d : rd_q + (AW+1)'(do_alloc);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= PWIDTH'(BASE + i);
         wr_q  <= (AW+1)'(DEPTH);
         rd_q  <= '0;
         crd_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         crd_q <= crd_d;
      end
   end

`ifdef FREELIST_CHECK_EN
   // in_list covers the committed region crd..wr, so a flush never touches it.
   logic [2**PWIDTH-1:0] in_list_q, in_list_d;
   logic                 fl_err_q, fl_err_d;

   assign free_legal = !list_full && !in_list_q[free_preg] && (free_preg != '0);
   assign fl_err     = fl_err_q;

   always_comb begin
      in_list_d = in_list_q;
      if (do_commit) in_list_d[mem_q[crd_q[AW-1:0]]] = 1'b0;
      if (do_free)   in_list_d[free_preg] = 1'b1;
      fl_err_d = fl_err_q
               | (free_req && !free_legal)
               | (alloc_req && !alloc_valid)
               | (commit_alloc && (crd_q == rd_q));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**PWIDTH; i++)
            in_list_q[i] <= (i >= BASE) && (i < BASE + DEPTH);
         fl_err_q <= 1'b0;
      end else begin
         in_list_q <= in_list_d;
         fl_err_q  <= fl_err_d;
      end
   end
`else
   assign free_legal = !list_full;
   assign fl_err     = 1'b0;
`endif

endmodule
